board_clear_ctrl: RTL

Line-clear sequencer for the Tetris board RAM (1 bit per cell, BOARD_W x BOARD_H, y=0 top row).
- gamelogic pulses start after a piece locks.
- The block scans every row bottom-to-top, removes full rows, compacts the remaining rows downward and zero-fills the vacated top rows.
- It then reports the number of lines cleared.
- It owns the board read/write ports while busy; gamelogic must not access the board while busy=1.

---
 rtl/board_clear_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/board_clear_ctrl.sv
// board_clear_ctrl: scans the Tetris board RAM bottom-to-top, removes full rows, compacts the rest down, zero-fills the top.
// Define BOARD_CLEAR_SCORE_EN to enable the per-run score table on score_pts; otherwise score_pts stays 0.
module board_clear_ctrl #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20,
  parameter int XW      = 4,
  parameter int YW      = 5
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [YW-1:0] lines_cleared,
  output logic [3:0]    score_pts,
  output logic [XW-1:0] board_rx,
  output logic [YW-1:0] board_ry,
  input  logic          board_rdata,
  output logic          board_we,
  output logic [XW-1:0] board_wx,
  output logic [YW-1:0] board_wy,
  output logic          board_wdata
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_EVAL, S_COPY, S_FILL, S_DONE} state_e;

  localparam logic [XW-1:0] X_LAST     = XW'(BOARD_W - 1);
  localparam logic [XW-1:0] X_READ_END = XW'(BOARD_W);
  localparam logic [YW-1:0] Y_BOTTOM   = YW'(BOARD_H - 1);

  state_e             state_q, state_d;
  logic [YW-1:0]      r_q, r_d;
  logic [YW-1:0]      dst_q, dst_d;
  logic [YW-1:0]      cnt_q, cnt_d;
  logic [YW-1:0]      lines_q, lines_d;
  logic [XW-1:0]      x_q, x_d;
  logic [XW-1:0]      x_prev;
  logic [BOARD_W-1:0] rowbuf_q, rowbuf_d;
  logic [3:0]         score_q, score_d;
  logic               row_done;

`ifdef BOARD_CLEAR_SCORE_EN
  function automatic logic [3:0] score_of(input logic [YW-1:0] n);
    case (n)
      YW'(0):  return 4'd0;
      YW'(1):  return 4'd1;
      YW'(2):  return 4'd3;
      YW'(3):  return 4'd5;
      default: return 4'd8;
    endcase
  endfunction
`endif

  // NOTE: rowbuf is a handful of flops rather than a RAM, so it is reset along with the other registers.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      r_q      <= '0;
      dst_q    <= '0;
      cnt_q    <= '0;
      x_q      <= '0;
      rowbuf_q <= '0;
      lines_q  <= '0;
      score_q  <= '0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      dst_q    <= dst_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      rowbuf_q <= rowbuf_d;
      lines_q  <= lines_d;
      score_q  <= score_d;
    end
  end

  always_comb begin
    // NOTE: every next-state value defaults to its register so no branch can infer a latch.
    state_d  = state_q;
    r_d      = r_q;
    dst_d    = dst_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    rowbuf_d = rowbuf_q;
    lines_d  = lines_q;
    score_d  = score_q;
    row_done = 1'b0;
    x_prev   = x_q - 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          r_d     = Y_BOTTOM;
          dst_d   = Y_BOTTOM;
          cnt_d   = '0;
          x_d     = '0;
          lines_d = '0;
          score_d = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        // Read data lags the address by one cycle, so cycle x lands the cell addressed at x-1.
        if (x_q != '0) rowbuf_d[x_prev] = board_rdata;
        if (x_q == X_READ_END) begin
          x_d     = '0;
          state_d = S_EVAL;
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      S_EVAL: begin
        if (&rowbuf_q) begin
          cnt_d    = cnt_q + 1'b1;
          row_done = 1'b1;
        end else if (dst_q == r_q) begin
          dst_d    = dst_q - 1'b1;
          row_done = 1'b1;
        end else begin
          state_d = S_COPY;
        end
      end
      S_COPY: begin
        if (x_q == X_LAST) begin
          x_d      = '0;
          dst_d    = dst_q - 1'b1;
          row_done = 1'b1;
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      S_FILL: begin
        if (x_q == X_LAST) begin
          x_d = '0;
          if (dst_q == '0) state_d = S_DONE;
          else             dst_d   = dst_q - 1'b1;
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Shared exit once a source row is finished: either step up a row or wrap up the scan.
    if (row_done) begin
      if (r_q == '0) begin
        if (cnt_d != '0) begin
          state_d = S_FILL;
          dst_d   = cnt_d - 1'b1;
        end else begin
          state_d = S_DONE;
        end
      end else begin
        r_d     = r_q - 1'b1;
        state_d = S_READ;
      end
    end

    // Results are loaded on entry so they are already valid during the done pulse.
    if (state_d == S_DONE && state_q != S_DONE) begin
      lines_d = cnt_d;
`ifdef BOARD_CLEAR_SCORE_EN
      score_d = score_of(cnt_d);
`endif
    end
  end

  always_comb begin
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
    board_rx    = '0;
    board_ry    = '0;
    board_we    = 1'b0;
    board_wx    = '0;
    board_wy    = '0;
    board_wdata = 1'b0;
    case (state_q)
      S_READ: begin
        if (x_q != X_READ_END) begin
          board_rx = x_q;
          board_ry = r_q;
        end
      end
      S_COPY: begin
        board_we    = 1'b1;
        board_wx    = x_q;
        board_wy    = dst_q;
        board_wdata = rowbuf_q[x_q];
      end
      S_FILL: begin
        board_we = 1'b1;
        board_wx = x_q;
        board_wy = dst_q;
      end
      default: ;
    endcase
  end

  assign lines_cleared = lines_q;
  assign score_pts     = score_q;

endmodule
